iotdf_sched: RTL

Round-granular scheduler sitting in front of the IOTDF engine. Arbitrates round-robin among N_REQ sensor requesters, each offering 128-bit samples plus a 3-bit function code. It serializes one full round (8 samples, 16 bytes each) from the winner onto the engine's byte interface. It resets the engine between owners, aborts broken rounds, and tags engine results with the owning requester id.

---
 rtl/iotdf_sched_if.sv | 32 +++
 rtl/iotdf_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/iotdf_sched_if.sv
// iotdf_sched_if: requester, engine and result signals of the IOTDF round scheduler
interface iotdf_sched_if #(
    parameter int N_REQ = 4,
    parameter int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*128-1:0] req_data;
    logic [N_REQ*3-1:0]   req_fn;
    logic [N_REQ-1:0]     req_ready;
    logic                 in_en;
    logic [7:0]           iot_in;
    logic [2:0]           fn_sel;
    logic                 dtf_rst;
    logic                 busy;
    logic                 valid;
    logic [127:0]         iot_out;
    logic                 res_valid;
    logic [127:0]         res_data;
    logic [IW-1:0]        res_id;
    logic                 err;
    logic [IW-1:0]        err_id;

    modport slave (
        input  req_valid, req_data, req_fn, busy, valid, iot_out,
        output req_ready, in_en, iot_in, fn_sel, dtf_rst, res_valid, res_data, res_id, err, err_id
    );

    modport master (
        output req_valid, req_data, req_fn, busy, valid, iot_out,
        input  req_ready, in_en, iot_in, fn_sel, dtf_rst, res_valid, res_data, res_id, err, err_id
    );
endinterface

// File: rtl/iotdf_sched.sv
// iotdf_sched: round-robin round scheduler feeding the IOTDF byte interface and tagging its results
module iotdf_sched #(
    parameter int N_REQ = 4,
    parameter int WORDS = 8,
    parameter int DRAIN = 4
) (
    input logic clk,
    input logic rst,
    iotdf_sched_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(WORDS) + 1;
    localparam int CW = $clog2(DRAIN + 16) + 1;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_RSTP  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;
    localparam logic [2:0] ST_DRN   = 3'd5;
    localparam logic [2:0] ST_ABORT = 3'd6;

    logic [2:0]    state;
    logic [IW-1:0] ptr, owner, prev_owner, winner, nxt_ptr;
    logic [2:0]    fn, prev_fn;
    logic          has_prev, granted, last_byte, more, own_valid, sending;
    logic [127:0]  shift, own_data;
    logic [CW-1:0] cnt;
    logic [WW-1:0] word_cnt;

    // winner is the first valid requester scanning upward from ptr
    always_comb begin
        winner = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req_valid[(int'(ptr) + k) % N_REQ]) winner = IW'((int'(ptr) + k) % N_REQ);
    end

    assign sending   = state == ST_SEND;
    assign last_byte = sending && cnt == CW'(15);
    assign more      = word_cnt != WW'(WORDS - 1);
    assign own_valid = bus.req_valid[owner];
    assign own_data  = bus.req_data[int'(owner)*128 +: 128];
    assign nxt_ptr   = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // ready only on the load cycle and on the last byte of a non-final sample
    always_comb begin
        bus.req_ready = '0;
        if (state == ST_LOAD || (last_byte && more)) bus.req_ready[owner] = 1'b1;
    end

    assign bus.in_en   = sending;
    assign bus.iot_in  = sending ? shift[127:120] : 8'd0;
    assign bus.fn_sel  = fn;
    assign bus.dtf_rst = rst | (state == ST_RSTP && cnt == '0) | (state == ST_ABORT);
    assign bus.err     = state == ST_ABORT;
    assign bus.err_id  = (state == ST_ABORT) ? owner : '0;

    // round sequencing: grant, optional engine reset, sample streaming, drain or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            fn         <= '0;
            prev_owner <= '0;
            prev_fn    <= '0;
            has_prev   <= 1'b0;
            granted    <= 1'b0;
            shift      <= '0;
            cnt        <= '0;
            word_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|bus.req_valid && !bus.busy) begin
                    owner   <= winner;
                    fn      <= bus.req_fn[int'(winner)*3 +: 3];
                    granted <= 1'b1;
                    state   <= ST_ARB;
                end
                ST_ARB: begin
                    has_prev   <= 1'b1;
                    prev_owner <= owner;
                    prev_fn    <= fn;
                    cnt        <= '0;
                    state      <= (!has_prev || owner != prev_owner || fn != prev_fn) ? ST_RSTP : ST_LOAD;
                end
                ST_RSTP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt != '0) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift    <= own_data;
                    word_cnt <= '0;
                    cnt      <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: if (!last_byte) begin
                    shift <= shift << 8;
                    cnt   <= cnt + 1'b1;
                end else if (more) begin
                    if (own_valid) begin
                        shift    <= own_data;
                        word_cnt <= word_cnt + 1'b1;
                        cnt      <= '0;
                    end else state <= ST_ABORT;
                end else begin
                    cnt   <= '0;
                    ptr   <= nxt_ptr;
                    state <= ST_DRN;
                end
                ST_DRN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DRAIN - 1)) state <= ST_IDLE;
                end
                ST_ABORT: begin
                    has_prev <= 1'b0;
                    ptr      <= nxt_ptr;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // engine results are tagged with the owner one cycle later; dropped before any grant and while the engine resets
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
        end else begin
            bus.res_valid <= bus.valid && granted && state != ST_RSTP && state != ST_ABORT;
            bus.res_data  <= bus.iot_out;
            bus.res_id    <= owner;
        end
    end
endmodule
